// File: rtl/pipe_hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package pipe_hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_BUSY  = 2'b01,
        MD_DRAIN = 2'b10
    } md_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/pipe_hazard_unit_muldiv_stall_timer.sv
// Multi-cycle mul/div EX stall sequencer: stalls the front end while a
// mul/div occupies EX, then releases for the draining cycle.
module muldiv_stall_timer
    import pipe_hazard_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_muldiv,
    output logic stall
);

    localparam int unsigned CW       = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
    // The IDLE detect cycle plus BUSY_CYC busy cycles give MULDIV_LAT-1 stalls.
    localparam int unsigned BUSY_CYC = (MULDIV_LAT > 2) ? MULDIV_LAT - 2 : 0;
    localparam logic [CW-1:0] CNT_LOAD = CW'((BUSY_CYC > 0) ? BUSY_CYC - 1 : 0);

    md_state_t     state;
    logic [CW-1:0] cnt;
    logic          busy_q;
    logic          start;

    assign start = (state == MD_IDLE) && ex_muldiv && (MULDIV_LAT > 1);
    assign stall = rst && (busy_q || start);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        if (BUSY_CYC == 0) begin
                            state  <= MD_DRAIN;
                            busy_q <= 1'b0;
                        end else begin
                            state  <= MD_BUSY;
                            cnt    <= CNT_LOAD;
                            busy_q <= 1'b1;
                        end
                    end
                end
                MD_BUSY: begin
                    if (cnt == '0) begin
                        state  <= MD_DRAIN;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MD_DRAIN: begin
                    state  <= MD_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= MD_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 16-bit 5-stage pipeline: forwarding,
// load-use stall, branch/jump flush, mul/div stall and perf counters.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_jump,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic                  ex_muldiv,
    input  logic                  ex_branch_taken,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regwrite,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  idex_hold,
    output logic                  exmem_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    function automatic logic match(input logic [REG_ADDR_W-1:0] r,
                                   input logic [REG_ADDR_W-1:0] d,
                                   input logic                  we);
        return we && (r == d) && !((ZERO_REG != 0) && (d == '0));
    endfunction

    logic     md_stall;
    logic     load_use;
    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    muldiv_stall_timer #(
        .MULDIV_LAT(MULDIV_LAT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .ex_muldiv(ex_muldiv),
        .stall    (md_stall)
    );

    assign load_use = ex_memread &&
                      ((id_uses_rs && match(id_rs, ex_rd, ex_regwrite)) ||
                       (id_uses_rt && match(id_rt, ex_rd, ex_regwrite)));

    always_comb begin
        sel_a = FWD_RF;
        if (match(ex_rs, mem_rd, mem_regwrite))
            sel_a = FWD_EXMEM;
        else if (match(ex_rs, wb_rd, wb_regwrite))
            sel_a = FWD_MEMWB;
    end

    always_comb begin
        sel_b = FWD_RF;
        if (match(ex_rt, mem_rd, mem_regwrite))
            sel_b = FWD_EXMEM;
        else if (match(ex_rt, wb_rd, wb_regwrite))
            sel_b = FWD_MEMWB;
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        fwd_a        = FWD_RF;
        fwd_b        = FWD_RF;
        if (rst) begin
            fwd_a = sel_a;
            fwd_b = sel_b;
            if (md_stall) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_hold    = 1'b1;
                exmem_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                // A taken branch squashes the dependent instruction, so no load-use stall.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else if (id_jump) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed self-checking bench for pipe_hazard_unit (MULDIV_LAT=4, CNT_W=4).
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs, id_uses_rt, id_jump;
    logic       ex_regwrite, ex_memread, ex_muldiv, ex_branch_taken;
    logic       mem_regwrite, wb_regwrite;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(
        .REG_ADDR_W(4),
        .ZERO_REG  (1),
        .MULDIV_LAT(4),
        .CNT_W     (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_jump        (id_jump),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_muldiv      (ex_muldiv),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd         (mem_rd),
        .mem_regwrite   (mem_regwrite),
        .wb_rd          (wb_rd),
        .wb_regwrite    (wb_regwrite),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .idex_hold      (idex_hold),
        .exmem_bubble   (exmem_bubble),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then let inputs/outputs settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0; id_jump = 0;
        ex_rs = '0; ex_rt = '0; ex_rd = '0;
        ex_regwrite = 0; ex_memread = 0; ex_muldiv = 0; ex_branch_taken = 0;
        mem_rd = '0; mem_regwrite = 0; wb_rd = '0; wb_regwrite = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 4'd5; id_rs = 4'd5; id_uses_rs = 1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #1;
        tick();
        // Reset with events pending: outputs must stay quiescent.
        ex_muldiv = 1; id_jump = 1; set_load_use();
        #1;
        check("rst_pc_write", pc_write, 1);
        check("rst_ifid_write", ifid_write, 1);
        check("rst_ifid_flush", ifid_flush, 0);
        check("rst_idex_bubble", idex_bubble, 0);
        check("rst_idex_hold", idex_hold, 0);
        tick();
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        clear_inputs();
        rst = 1'b1;
        tick();

        // Forwarding
        mem_rd = 4'd3; mem_regwrite = 1; wb_rd = 4'd3; wb_regwrite = 1; ex_rs = 4'd3; ex_rt = 4'd7;
        #1;
        check("fwd_a_exmem_prio", fwd_a, 2'b01);
        check("fwd_b_none", fwd_b, 2'b00);
        mem_regwrite = 0; ex_rt = 4'd3;
        #1;
        check("fwd_a_memwb", fwd_a, 2'b10);
        check("fwd_b_memwb", fwd_b, 2'b10);
        ex_rs = 4'd0; ex_rt = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0; mem_regwrite = 1;
        #1;
        check("fwd_a_zero_reg", fwd_a, 2'b00);
        check("fwd_b_zero_reg", fwd_b, 2'b00);
        check("fwd_no_stall", pc_write, 1);
        clear_inputs();

        // Load-use: unused operand does not stall, used one does for one cycle
        set_load_use();
        id_uses_rs = 0;
        #1;
        check("lu_unused_pc_write", pc_write, 1);
        id_uses_rs = 1;
        #1;
        check("lu_pc_write", pc_write, 0);
        check("lu_ifid_write", ifid_write, 0);
        check("lu_idex_bubble", idex_bubble, 1);
        check("lu_idex_hold", idex_hold, 0);
        tick();
        ex_memread = 0; ex_regwrite = 0;
        #1;
        check("lu_release", pc_write, 1);
        check("lu_stall_cnt", stall_cnt, 1);
        clear_inputs();

        // Mul/div, latency 4: three stall cycles then DRAIN
        do_reset();
        ex_muldiv = 1;
        #1;
        check("md_c0_pc_write", pc_write, 0);
        check("md_c0_idex_hold", idex_hold, 1);
        check("md_c0_exmem_bubble", exmem_bubble, 1);
        check("md_c0_idex_bubble", idex_bubble, 0);
        tick();
        ex_branch_taken = 1; id_jump = 1;
        #1;
        check("md_c1_pc_write", pc_write, 0);
        check("md_c1_branch_ignored", ifid_flush, 0);
        ex_branch_taken = 0; id_jump = 0;
        tick();
        check("md_c2_pc_write", pc_write, 0);
        tick();
        check("md_drain_pc_write", pc_write, 1);
        check("md_drain_idex_hold", idex_hold, 0);
        check("md_stall_cnt", stall_cnt, 3);
        ex_muldiv = 0;
        tick();
        check("md_idle_pc_write", pc_write, 1);
        check("md_stall_cnt_hold", stall_cnt, 3);
        check("md_flush_cnt", flush_cnt, 0);

        // Branch and load-use in the same cycle; then a plain jump
        ex_branch_taken = 1; set_load_use();
        #1;
        check("br_ifid_flush", ifid_flush, 1);
        check("br_idex_bubble", idex_bubble, 1);
        check("br_pc_write", pc_write, 1);
        check("br_ifid_write", ifid_write, 1);
        tick();
        clear_inputs();
        id_jump = 1;
        #1;
        check("br_flush_cnt", flush_cnt, 1);
        check("jmp_ifid_flush", ifid_flush, 1);
        check("jmp_idex_bubble", idex_bubble, 0);
        check("jmp_pc_write", pc_write, 1);
        tick();
        check("jmp_flush_cnt", flush_cnt, 2);
        check("br_stall_cnt", stall_cnt, 3);
        clear_inputs();

        // Reset during BUSY aborts the stall
        do_reset();
        ex_muldiv = 1;
        tick();
        tick();
        rst = 1'b0; ex_muldiv = 0;
        #1;
        check("rb_quiescent_pc_write", pc_write, 1);
        check("rb_quiescent_idex_hold", idex_hold, 0);
        tick();
        rst = 1'b1;
        #1;
        check("rb_stall_cnt", stall_cnt, 0);
        check("rb_flush_cnt", flush_cnt, 0);
        check("rb_idle_pc_write", pc_write, 1);
        tick();
        check("rb_idle2_pc_write", pc_write, 1);
        check("rb_stall_cnt2", stall_cnt, 0);

        // Counter saturation at 4 bits
        set_load_use();
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", stall_cnt, 14);
        tick();
        check("sat_15", stall_cnt, 15);
        for (int i = 0; i < 6; i++) tick();
        check("sat_hold", stall_cnt, 15);
        check("sat_still_stalling", pc_write, 0);
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
